// File: rtl/pe_pkg.sv
// Shared types and helpers for the convolution engine: FSM state encoding,
// output-dimension calculation and a wide saturating adder.
package pe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    // Internal width used for accumulation before clamping to ACC_W.
    localparam int SAT_W = 64;

    typedef struct packed {
        logic                    ovf;
        logic signed [SAT_W-1:0] val;
    } sat_res_t;

    function automatic int out_dim(input int img, input int filt, input int stride);
        return (img - filt) / stride + 1;
    endfunction

    // Address width for n locations, never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // a + b clamped to the signed range of a w-bit word (w <= 62 keeps the
    // 64-bit sum itself free of overflow).
    function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] a,
                                         input logic signed [SAT_W-1:0] b,
                                         input int w);
        logic signed [SAT_W-1:0] lim_hi;
        logic signed [SAT_W-1:0] lim_lo;
        logic signed [SAT_W-1:0] sum;
        sat_res_t                res;
        lim_hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        lim_lo  = -lim_hi - 64'sd1;
        sum     = a + b;
        res.ovf = 1'b0;
        res.val = sum;
        if (sum > lim_hi) begin
            res.ovf = 1'b1;
            res.val = lim_hi;
        end else if (sum < lim_lo) begin
            res.ovf = 1'b1;
            res.val = lim_lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/pe_mac_lane.sv
// One channel multiplier: unsigned pixel times signed weight.
module pe_mac_lane
    import pe_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0]        pix,
    input  logic [DATA_W-1:0]        wgt,
    output logic signed [2*DATA_W:0] prod
);

    logic signed [2*DATA_W:0] pix_ext;
    logic signed [2*DATA_W:0] wgt_ext;

    // Extend both operands to the full product width so the multiply is
    // a plain signed multiply with no mixed-signedness surprises.
    assign pix_ext = {{DATA_W{1'b0}}, pix};
    assign wgt_ext = {{(DATA_W + 1){wgt[DATA_W-1]}}, wgt};
    assign prod    = pix_ext * wgt_ext;

endmodule

// File: rtl/pe_conv_engine.sv
// Single-PE 2-D convolution engine. Walks every output pixel, issuing one
// filter tap per cycle to external image/filter memories (1-cycle latency),
// accumulates with saturation and writes one result per window.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for start, all outputs quiet
//   ISSUE    | presenting tap addresses, one tap per cycle
//   DRAIN    | absorbing the final tap's read data
//   WRITE    | out_wr_en high for one cycle with the window result
//   FIN      | done pulse, return to IDLE
module pe_conv_engine
    import pe_pkg::*;
#(
    parameter int NUM_CH    = 1,
    parameter int IMG_SIZE  = 16,
    parameter int FILT_SIZE = 4,
    parameter int STRIDE    = 1,
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 32
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic                                    relu_en,
    output logic                                    busy,
    output logic                                    done,
    output logic [addr_w(IMG_SIZE*IMG_SIZE)-1:0]    img_rd_addr,
    input  logic [NUM_CH*DATA_W-1:0]                img_rd_data,
    output logic [addr_w(FILT_SIZE*FILT_SIZE)-1:0]  flt_rd_addr,
    input  logic [NUM_CH*DATA_W-1:0]                flt_rd_data,
    output logic                                    out_wr_en,
    output logic [addr_w(out_dim(IMG_SIZE, FILT_SIZE, STRIDE) *
                         out_dim(IMG_SIZE, FILT_SIZE, STRIDE))-1:0] out_wr_addr,
    output logic [ACC_W-1:0]                        out_wr_data
);

    localparam int OUT_DIM = out_dim(IMG_SIZE, FILT_SIZE, STRIDE);
    localparam int IMG_AW  = addr_w(IMG_SIZE * IMG_SIZE);
    localparam int FLT_AW  = addr_w(FILT_SIZE * FILT_SIZE);
    localparam int OUT_AW  = addr_w(OUT_DIM * OUT_DIM);
    localparam int FC_W    = addr_w(FILT_SIZE);
    localparam int OD_W    = addr_w(OUT_DIM);
    localparam int PROD_W  = 2 * DATA_W + 1;

    // Windows must tile the image exactly; anything else is a bad build.
    if (FILT_SIZE > IMG_SIZE || ((IMG_SIZE - FILT_SIZE) % STRIDE) != 0) begin : g_bad_geometry
        $error("pe_conv_engine: (IMG_SIZE-FILT_SIZE)/STRIDE is not an integer");
    end
    if (ACC_W > 62) begin : g_bad_acc_w
        $error("pe_conv_engine: ACC_W must not exceed 62");
    end

    state_t                   state;
    logic                     relu_q;
    logic [OD_W-1:0]          ox;
    logic [OD_W-1:0]          oy;
    logic [FC_W-1:0]          tr;
    logic [FC_W-1:0]          tc;
    logic                     tap_vld;
    logic                     tap_first;
    logic signed [ACC_W-1:0]  acc;
    logic                     sat_hold;
    logic signed [ACC_W-1:0]  acc_next;
    logic                     hold_next;
    logic signed [SAT_W-1:0]  tap_sum;
    sat_res_t                 sat_r;
    logic signed [PROD_W-1:0] prod [NUM_CH];
    logic [ACC_W-1:0]         relu_val;
    logic                     unused_sat_hi;

    function automatic logic [IMG_AW-1:0] pix_addr(input logic [OD_W-1:0] y,
                                                   input logic [OD_W-1:0] x,
                                                   input logic [FC_W-1:0] r,
                                                   input logic [FC_W-1:0] c);
        int a;
        a = (int'(y) * STRIDE + int'(r)) * IMG_SIZE + int'(x) * STRIDE + int'(c);
        return IMG_AW'(a);
    endfunction

    function automatic logic [FLT_AW-1:0] tap_addr(input logic [FC_W-1:0] r,
                                                   input logic [FC_W-1:0] c);
        return FLT_AW'(int'(r) * FILT_SIZE + int'(c));
    endfunction

    function automatic logic [OUT_AW-1:0] opix_addr(input logic [OD_W-1:0] y,
                                                    input logic [OD_W-1:0] x);
        return OUT_AW'(int'(y) * OUT_DIM + int'(x));
    endfunction

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lane
        pe_mac_lane #(.DATA_W(DATA_W)) u_lane (
            .pix  (img_rd_data[ch*DATA_W +: DATA_W]),
            .wgt  (flt_rd_data[ch*DATA_W +: DATA_W]),
            .prod (prod[ch])
        );
    end

    // Adder tree across channels, kept at full width so no channel sum wraps.
    always_comb begin
        tap_sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            tap_sum = tap_sum + SAT_W'(prod[i]);
        end
    end

    // Next accumulator value: restart on the first tap of a window, freeze
    // once the window has saturated.
    always_comb begin
        sat_r     = sat_add(tap_first ? 64'sd0 : SAT_W'(acc), tap_sum, ACC_W);
        acc_next  = acc;
        hold_next = sat_hold;
        if (tap_vld) begin
            if (tap_first || !sat_hold) begin
                acc_next  = sat_r.val[ACC_W-1:0];
                hold_next = sat_r.ovf;
            end
        end
    end

    // Upper bits of the clamped sum are only sign extension.
    assign unused_sat_hi = ^sat_r.val[SAT_W-1:ACC_W];
    assign relu_val      = (relu_q && acc_next[ACC_W-1]) ? '0 : acc_next;

    // Accumulator and saturation flag update on each sampled tap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            sat_hold <= 1'b0;
        end else if (tap_vld) begin
            acc      <= acc_next;
            sat_hold <= hold_next;
        end
    end

    // Sequencer: window/tap counters, memory addresses and write strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            out_wr_en   <= 1'b0;
            img_rd_addr <= '0;
            flt_rd_addr <= '0;
            out_wr_addr <= '0;
            out_wr_data <= '0;
            relu_q      <= 1'b0;
            ox          <= '0;
            oy          <= '0;
            tr          <= '0;
            tc          <= '0;
            tap_vld     <= 1'b0;
            tap_first   <= 1'b0;
        end else begin
            done      <= 1'b0;
            out_wr_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        relu_q      <= relu_en;
                        ox          <= '0;
                        oy          <= '0;
                        tr          <= '0;
                        tc          <= '0;
                        img_rd_addr <= '0;
                        flt_rd_addr <= '0;
                        busy        <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    tap_vld   <= 1'b1;
                    tap_first <= (tr == '0) && (tc == '0);
                    if (tc == FC_W'(FILT_SIZE - 1)) begin
                        tc <= '0;
                        if (tr == FC_W'(FILT_SIZE - 1)) begin
                            tr          <= '0;
                            img_rd_addr <= '0;
                            flt_rd_addr <= '0;
                            state       <= ST_DRAIN;
                        end else begin
                            tr          <= tr + 1'b1;
                            img_rd_addr <= pix_addr(oy, ox, tr + 1'b1, '0);
                            flt_rd_addr <= tap_addr(tr + 1'b1, '0);
                        end
                    end else begin
                        tc          <= tc + 1'b1;
                        img_rd_addr <= pix_addr(oy, ox, tr, tc + 1'b1);
                        flt_rd_addr <= tap_addr(tr, tc + 1'b1);
                    end
                end
                ST_DRAIN: begin
                    tap_vld     <= 1'b0;
                    out_wr_en   <= 1'b1;
                    out_wr_addr <= opix_addr(oy, ox);
                    out_wr_data <= relu_val;
                    state       <= ST_WRITE;
                end
                ST_WRITE: begin
                    out_wr_addr <= '0;
                    if (ox == OD_W'(OUT_DIM - 1)) begin
                        ox <= '0;
                        if (oy == OD_W'(OUT_DIM - 1)) begin
                            done  <= 1'b1;
                            state <= ST_FIN;
                        end else begin
                            oy          <= oy + 1'b1;
                            img_rd_addr <= pix_addr(oy + 1'b1, '0, '0, '0);
                            state       <= ST_ISSUE;
                        end
                    end else begin
                        ox          <= ox + 1'b1;
                        img_rd_addr <= pix_addr(oy, ox + 1'b1, '0, '0);
                        state       <= ST_ISSUE;
                    end
                end
                ST_FIN: begin
                    busy  <= 1'b0;
                    oy    <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_conv_engine.sv
// Bench for pe_conv_engine: four instances with different geometries, fed
// from synthetic 1-cycle-latency memories. Expected writes are queued when a
// layer is started; a monitor pops and compares every write it sees.
module tb_pe_conv_engine;
    import pe_pkg::addr_w;

    typedef struct {
        int inst;
        int addr;
        int data;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              start_v   [4];
    logic              relu_v    [4];
    logic              busy_v    [4];
    logic              done_v    [4];
    logic              wr_en_v   [4];
    logic [31:0]       wr_addr_v [4];
    logic signed [31:0] wr_data_v [4];
    logic [31:0]       img_addr_v [4];
    logic [31:0]       flt_addr_v [4];

    int   cyc;
    int   n_vec;
    int   n_err;
    exp_t sb [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents per instance.
    //  0: 4x4 image of 1s, 2x2 filter of 1s          -> every output 4
    //  1: ch0=2 ch1=3, weights ch0=+1 ch1=-1, 4x4     -> every output -16
    //  2: 8x8 image pixel=index, 2x2 ones, stride 2   -> 4p+18, p=16*oy+2*ox
    //  3: 255 pixels, 127 weights, 2 ch, 16-bit acc   -> saturates at 32767
    function automatic logic [15:0] img_word(input int k, input int a);
        case (k)
            0:       return 16'h0001;
            1:       return 16'h0302;
            2:       return 16'(a);
            default: return 16'hFFFF;
        endcase
    endfunction

    function automatic logic [15:0] flt_word(input int k);
        case (k)
            0:       return 16'h0001;
            1:       return 16'hFF01;
            2:       return 16'h0001;
            default: return 16'h7F7F;
        endcase
    endfunction

    function automatic int cfg_od(input int k);
        case (k)
            0:       return 3;
            1:       return 3;
            2:       return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int cfg_f(input int k);
        return (k == 0 || k == 2) ? 2 : 4;
    endfunction

    // Window at (2*ox, 2*oy): p + (p+1) + (p+8) + (p+9) for instance 2,
    // e.g. (0,0)=0+1+8+9=18 and ox=1 -> 2+3+10+11=26.
    function automatic int exp_val(input int k, input int ox, input int oy, input bit relu);
        case (k)
            0:       return 4;
            1:       return relu ? 0 : -16;
            2:       return 64 * oy + 8 * ox + 18;
            default: return 32767;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int NCH = (g == 1 || g == 3) ? 2 : 1;
        localparam int IMG = (g == 0) ? 4 : (g == 1) ? 6 : (g == 2) ? 8 : 5;
        localparam int FLT = (g == 0 || g == 2) ? 2 : 4;
        localparam int STR = (g == 2) ? 2 : 1;
        localparam int AW  = (g == 3) ? 16 : 32;
        localparam int OD  = (IMG - FLT) / STR + 1;
        localparam int DW  = NCH * 8;
        localparam int IAW = addr_w(IMG * IMG);
        localparam int FAW = addr_w(FLT * FLT);
        localparam int OAW = addr_w(OD * OD);

        logic [IAW-1:0] img_addr;
        logic [FAW-1:0] flt_addr;
        logic [OAW-1:0] o_addr;
        logic [AW-1:0]  o_data;
        logic [DW-1:0]  img_q;
        logic [DW-1:0]  flt_q;
        logic           o_en;
        logic           bsy;
        logic           dn;

        pe_conv_engine #(
            .NUM_CH    (NCH),
            .IMG_SIZE  (IMG),
            .FILT_SIZE (FLT),
            .STRIDE    (STR),
            .DATA_W    (8),
            .ACC_W     (AW)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start_v[g]),
            .relu_en     (relu_v[g]),
            .busy        (bsy),
            .done        (dn),
            .img_rd_addr (img_addr),
            .img_rd_data (img_q),
            .flt_rd_addr (flt_addr),
            .flt_rd_data (flt_q),
            .out_wr_en   (o_en),
            .out_wr_addr (o_addr),
            .out_wr_data (o_data)
        );

        always @(posedge clk) begin
            img_q <= DW'(img_word(g, int'(img_addr)));
            flt_q <= DW'(flt_word(g));
        end

        assign busy_v[g]     = bsy;
        assign done_v[g]     = dn;
        assign wr_en_v[g]    = o_en;
        assign wr_addr_v[g]  = 32'(o_addr);
        assign wr_data_v[g]  = 32'($signed(o_data));
        assign img_addr_v[g] = 32'(img_addr);
        assign flt_addr_v[g] = 32'(flt_addr);
    end

    task automatic chk(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (wr_en_v[k]) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_write: inst %0d addr %0d data %0d, expected no write",
                                 k, wr_addr_v[k], wr_data_v[k]);
                    end else begin
                        e = sb.pop_front();
                        chk("wr_inst", k, e.inst);
                        chk("wr_addr", int'(wr_addr_v[k]), e.addr);
                        chk("wr_data", int'(wr_data_v[k]), e.data);
                    end
                end
            end
        end
    endtask

    // Full layer on instance k. With mid set, start is re-pulsed while busy
    // (with relu_en flipped) and must change nothing.
    task automatic run_layer(input int k, input bit relu, input bit mid);
        int  od;
        int  f;
        int  exp_lat;
        int  s;
        int  d;
        bit  seen;
        od      = cfg_od(k);
        f       = cfg_f(k);
        exp_lat = od * od * (f * f + 2) + 2;
        for (int oy = 0; oy < od; oy++)
            for (int ox = 0; ox < od; ox++)
                sb.push_back('{k, oy * od + ox, exp_val(k, ox, oy, relu)});
        @(posedge clk); #1;
        start_v[k] = 1'b1;
        relu_v[k]  = relu;
        s          = cyc;
        @(posedge clk); #1;
        start_v[k] = 1'b0;
        relu_v[k]  = ~relu;
        @(negedge clk);
        chk("busy_run", busy_v[k], 1);
        if (mid) begin
            repeat (7) @(posedge clk);
            #1 start_v[k] = 1'b1;
            @(posedge clk);
            #1 start_v[k] = 1'b0;
        end
        seen = 1'b0;
        d    = 0;
        for (int i = 0; i < exp_lat + 20 && !seen; i++) begin
            @(negedge clk);
            if (done_v[k]) begin
                seen = 1'b1;
                d    = cyc;
            end
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: inst %0d no done within %0d cycles, expected done", k, exp_lat + 20);
        end else begin
            // Inclusive count: cycle carrying start through cycle carrying done.
            chk("done_latency", d - s + 1, exp_lat);
        end
        @(negedge clk);
        chk("done_pulse", done_v[k], 0);
        chk("busy_after", busy_v[k], 0);
        chk("sb_drained", sb.size(), 0);
        relu_v[k] = 1'b0;
    endtask

    // Start instance 0, let two windows complete, then reset during the
    // third window's tap issue: no further writes may appear.
    task automatic reset_abort();
        sb.push_back('{0, 0, 4});
        sb.push_back('{0, 1, 4});
        @(posedge clk); #1;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (13) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_busy", busy_v[0], 0);
        chk("abort_wr_en", wr_en_v[0], 0);
        chk("abort_img_addr", int'(img_addr_v[0]), 0);
        repeat (4) @(posedge clk);
        chk("abort_pending", sb.size(), 0);
        #1 rst = 1'b1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            start_v[k] = 1'b0;
            relu_v[k]  = 1'b0;
        end
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rst_flags", int'({busy_v[k], done_v[k], wr_en_v[k]}), 0);
            chk("rst_img_addr", int'(img_addr_v[k]), 0);
            chk("rst_flt_addr", int'(flt_addr_v[k]), 0);
            chk("rst_out_addr", int'(wr_addr_v[k]), 0);
        end
        @(posedge clk);
        #1 rst = 1'b1;

        run_layer(0, 1'b0, 1'b1);
        reset_abort();
        run_layer(0, 1'b0, 1'b0);
        run_layer(1, 1'b0, 1'b1);
        run_layer(1, 1'b1, 1'b0);
        run_layer(2, 1'b0, 1'b0);
        run_layer(3, 1'b0, 1'b0);
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
